// File: rtl/ssd_scanner_pkg.sv
// rtl/ssd_scanner_pkg.sv - glyph table, blank code and width helpers for the SSD scanner
package ssd_scanner_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry 15 (F) leftmost down to entry 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/ssd_scanner_hex7seg.sv
// rtl/ssd_scanner_hex7seg.sv - nibble to active-low seven-segment glyph, with forced blank
module ssd_scanner_hex7seg
  import ssd_scanner_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) seg = GLYPH_TABLE[nib];
  end

endmodule

// File: rtl/ssd_scanner.sv
// rtl/ssd_scanner.sv - multi-channel paged seven-segment scanner with per-frame snapshot
module ssd_scanner
  import ssd_scanner_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int CH          = 2,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  localparam int NIB        = DATA_W / 4,
  localparam int NPAGES     = (NIB + DIGITS - 1) / DIGITS,
  localparam int CSW        = clog2_min1(CH),
  localparam int PGW        = clog2_min1(NPAGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CSW-1:0]       ch_sel,
  input  logic                 page_btn,
  input  logic                 blank_lz,
  input  logic [CH*DATA_W-1:0] data_in,
  output logic [DIGITS-1:0]    anode,
  output logic [6:0]           cathode,
  output logic [PGW-1:0]       page_out
);

  localparam int DW   = clog2_min1(DIGITS);
  localparam int CW   = clog2_min1(REFRESH_DIV);
  localparam int IW   = clog2(NPAGES * DIGITS) + 1;
  localparam int CSW1 = CSW + 1;
  localparam logic [DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam seg_t              CA_OFF = (ACTIVE_LOW != 0) ? GLYPH_BLANK : ~GLYPH_BLANK;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [PGW-1:0]    page_q, page_d;
  logic              pend_q, pend_d;
  logic              btn_q, btn_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [CSW-1:0]    chan_q, chan_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  seg_t              cathode_q, cathode_d;
  logic [PGW-1:0]    page_out_q, page_out_d;

  logic              last_cnt, last_digit, fb, btn_rise;
  logic [CSW-1:0]    sel;
  logic [DATA_W-1:0] chan_data;
  logic [IW-1:0]     nib_idx, lz_top;
  logic [3:0]        nib;
  logic              nib_blank;
  seg_t              glyph;
  logic [DIGITS-1:0] onehot;

  always_comb begin
    sel = ch_sel;
    if ({1'b0, ch_sel} >= CSW1'(CH)) sel = '0;
    chan_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (sel == CSW'(c)) chan_data = data_in[c*DATA_W +: DATA_W];
    end
  end

  // Frame boundary: end of the last digit's slot, or the very first edge after reset.
  always_comb begin
    last_cnt   = (cnt_q == CW'(REFRESH_DIV - 1));
    last_digit = (digit_q == DW'(DIGITS - 1));
    fb         = load_q | (last_cnt & last_digit);
    btn_d      = page_btn;
    btn_rise   = page_btn & ~btn_q;

    cnt_d   = last_cnt ? '0 : cnt_q + CW'(1);
    digit_d = digit_q;
    if (last_cnt) digit_d = last_digit ? '0 : digit_q + DW'(1);

    page_d = page_q;
    pend_d = pend_q | btn_rise;
    snap_d = snap_q;
    chan_d = chan_q;
    load_d = load_q;
    if (fb) begin
      snap_d = chan_data;
      chan_d = sel;
      load_d = 1'b0;
      pend_d = btn_rise;
      if (sel != chan_q) page_d = '0;
      else if (pend_q) page_d = (page_q == PGW'(NPAGES - 1)) ? '0 : page_q + PGW'(1);
    end
  end

  always_comb begin
    nib_idx = IW'(page_q) * IW'(DIGITS) + IW'(digit_q);
    nib     = '0;
    lz_top  = '0;
    for (int i = 0; i < NIB; i++) begin
      if (nib_idx == IW'(i)) nib = snap_q[i*4 +: 4];
      if (snap_q[i*4 +: 4] != 4'h0) lz_top = IW'(i);
    end
    nib_blank = (nib_idx >= IW'(NIB)) || (blank_lz && (nib_idx > lz_top));
  end

  ssd_scanner_hex7seg u_hex7seg (
    .nib   (nib),
    .blank (nib_blank),
    .seg   (glyph)
  );

  // Outputs stay dark until the first snapshot has been taken.
  always_comb begin
    onehot     = DIGITS'(1) << digit_q;
    anode_d    = AN_OFF;
    cathode_d  = CA_OFF;
    page_out_d = page_q;
    if (!load_q) begin
      anode_d   = (ACTIVE_LOW != 0) ? ~onehot : onehot;
      cathode_d = (ACTIVE_LOW != 0) ? glyph : ~glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      digit_q    <= '0;
      page_q     <= '0;
      pend_q     <= 1'b0;
      btn_q      <= 1'b0;
      load_q     <= 1'b1;
      snap_q     <= '0;
      chan_q     <= '0;
      anode_q    <= AN_OFF;
      cathode_q  <= CA_OFF;
      page_out_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      page_q     <= page_d;
      pend_q     <= pend_d;
      btn_q      <= btn_d;
      load_q     <= load_d;
      snap_q     <= snap_d;
      chan_q     <= chan_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
      page_out_q <= page_out_d;
    end
  end

  assign anode    = anode_q;
  assign cathode  = cathode_q;
  assign page_out = page_out_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// tb/tb_ssd_scanner.sv - scoreboard bench for ssd_scanner, active-low and active-high builds
module tb_ssd_scanner;

  localparam logic [31:0] D0 = 32'h1234ABCD;
  localparam logic [31:0] D1 = 32'h89EF0567;
  localparam logic [31:0] D2 = 32'h55667788;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  ch_sel = 1'b0;
  logic        page_btn = 1'b0;
  logic        blank_lz = 1'b0;
  logic [63:0] data_in = 64'h0;
  logic [3:0]  an_l, an_h;
  logic [6:0]  ca_l, ca_h;
  logic [0:0]  pg_l, pg_h;

  int compared = 0;
  int mismatched = 0;
  int unsigned edge_n;

  typedef struct {
    logic [3:0] an;
    logic [6:0] ca;
    logic       pg;
  } exp_t;
  exp_t sb[$];

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  ssd_scanner #(.DIGITS(4), .CH(2), .DATA_W(32), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel), .page_btn(page_btn), .blank_lz(blank_lz),
    .data_in(data_in), .anode(an_l), .cathode(ca_l), .page_out(pg_l)
  );

  ssd_scanner #(.DIGITS(4), .CH(2), .DATA_W(32), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel), .page_btn(page_btn), .blank_lz(blank_lz),
    .data_in(data_in), .anode(an_h), .cathode(ca_h), .page_out(pg_h)
  );

  function automatic logic [6:0] exp_glyph(input logic [31:0] d, input int pg, input int dig,
                                           input bit blz);
    int idx;
    int h;
    logic [3:0] n;
    idx = pg * 4 + dig;
    h = 0;
    for (int i = 0; i < 8; i++) if (d[i*4 +: 4] != 4'h0) h = i;
    if (idx >= 8) return 7'h7F;
    if (blz && idx > h) return 7'h7F;
    n = d[idx*4 +: 4];
    return glyph_tab[n];
  endfunction

  task automatic wait_edge(input int unsigned k, input string tag);
    for (int i = 0; i < 4000 && edge_n < k; i++) @(negedge clk);
    if (edge_n != k) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: at edge %0d, wanted edge %0d", tag, edge_n, k);
    end
  endtask

  task automatic pulse_btn();
    @(negedge clk) page_btn = 1'b1;
    @(negedge clk) page_btn = 1'b0;
  endtask

  task automatic frame_check(input int unsigned fb, input logic [31:0] d, input int pg,
                             input bit blz, input string tag);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.an = ~(4'b0001 << (k / 4));
      e.ca = exp_glyph(d, pg, k / 4, blz);
      e.pg = pg[0];
      sb.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_edge(fb + k, tag);
      e = sb.pop_front();
      compared++;
      if ({an_l, ca_l, pg_l} !== {e.an, e.ca, e.pg}) begin
        mismatched++;
        $display("FAIL %s low edge %0d: got an=%b ca=%h pg=%0d, need an=%b ca=%h pg=%0d",
                 tag, edge_n, an_l, ca_l, pg_l, e.an, e.ca, e.pg);
      end
      compared++;
      if ({an_h, ca_h, pg_h} !== {~e.an, ~e.ca, e.pg}) begin
        mismatched++;
        $display("FAIL %s high edge %0d: got an=%b ca=%h pg=%0d, need an=%b ca=%h pg=%0d",
                 tag, edge_n, an_h, ca_h, pg_h, ~e.an, ~e.ca, e.pg);
      end
    end
  endtask

  task automatic check_off(input string tag);
    compared++;
    if ({an_l, ca_l, pg_l} !== {4'hF, 7'h7F, 1'b0}) begin
      mismatched++;
      $display("FAIL %s low: got an=%b ca=%h pg=%0d, need an=1111 ca=7f pg=0", tag, an_l, ca_l, pg_l);
    end
    compared++;
    if ({an_h, ca_h, pg_h} !== {4'h0, 7'h00, 1'b0}) begin
      mismatched++;
      $display("FAIL %s high: got an=%b ca=%h pg=%0d, need an=0000 ca=00 pg=0", tag, an_h, ca_h, pg_h);
    end
  endtask

  task automatic check_first(input logic [6:0] g, input string tag);
    compared++;
    if ({an_l, ca_l, pg_l} !== {4'b1110, g, 1'b0}) begin
      mismatched++;
      $display("FAIL %s low: got an=%b ca=%h pg=%0d, need an=1110 ca=%h pg=0", tag, an_l, ca_l, pg_l, g);
    end
    compared++;
    if ({an_h, ca_h, pg_h} !== {4'b0001, ~g, 1'b0}) begin
      mismatched++;
      $display("FAIL %s high: got an=%b ca=%h pg=%0d, need an=0001 ca=%h pg=0", tag, an_h, ca_h, pg_h, ~g);
    end
  endtask

  task automatic test_reset();
    data_in = {D1, D0};
    repeat (2) @(negedge clk);
    check_off("reset_hold");
    rst_n = 1'b1;
    wait_edge(1, "reset_edge1");
    check_off("reset_edge1");
    wait_edge(2, "reset_edge2");
    check_first(7'h21, "reset_edge2");
  endtask

  task automatic test_scan();
    frame_check(16, D0, 0, 1'b0, "scan");
  endtask

  task automatic test_page();
    pulse_btn();
    frame_check(48, D0, 1, 1'b0, "page_step");
    pulse_btn();
    @(negedge clk);
    pulse_btn();
    frame_check(80, D0, 0, 1'b0, "page_wrap_once");
  endtask

  task automatic test_lz();
    data_in[31:0] = 32'h0000002F;
    blank_lz = 1'b1;
    frame_check(112, 32'h0000002F, 0, 1'b1, "lz_page0");
    pulse_btn();
    frame_check(144, 32'h0000002F, 1, 1'b1, "lz_page1");
    data_in[31:0] = 32'h0;
    pulse_btn();
    frame_check(176, 32'h0, 0, 1'b1, "lz_zero");
  endtask

  task automatic test_midframe();
    data_in[31:0] = D0;
    blank_lz = 1'b0;
    frame_check(208, D0, 0, 1'b0, "mid_pre");
    fork
      frame_check(224, D0, 0, 1'b0, "mid_hold");
      begin
        wait_edge(230, "mid_change");
        data_in[31:0] = D2;
      end
    join
    frame_check(240, D2, 0, 1'b0, "mid_new");
  endtask

  task automatic test_chsel();
    pulse_btn();
    frame_check(272, D2, 1, 1'b0, "chsel_page1");
    ch_sel = 1'b1;
    pulse_btn();
    frame_check(304, D1, 0, 1'b0, "chsel_switch");
    frame_check(320, D1, 0, 1'b0, "chsel_pend_clr");
  endtask

  task automatic test_reset_mid();
    pulse_btn();
    frame_check(352, D1, 1, 1'b0, "rmid_page1");
    wait_edge(370, "rmid_wait");
    #2 rst_n = 1'b0;
    #1 check_off("rmid_assert");
    @(negedge clk) rst_n = 1'b1;
    wait_edge(1, "rmid_edge1");
    check_off("rmid_edge1");
    wait_edge(2, "rmid_edge2");
    check_first(7'h78, "rmid_edge2");
    frame_check(16, D1, 0, 1'b0, "rmid_frame");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_page();
    test_lz();
    test_midframe();
    test_chsel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
